cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

- Physical-memory-side responder for the L2's 256-bit `pmem_*` line interface.
- Accepts one line read or write and converts it into a 4-beat, 64-bit burst transaction on the DRAM-facing `burst_*` interface.
- Collects or serialises the beats, then returns a single-cycle `pmem_resp`.
- Sits between `l2_cache` and the memory model/controller; one transaction in flight at a time.

## Interface

- `s_offset`, default 5: line offset bits; line address alignment.
- `s_line`, default 256: line width in bits.
- `s_beat`, default 64: burst beat width in bits; beats per line = `s_line/s_beat` (4).
- `TIMEOUT`, default 255: watchdog limit in cycles (used only with `BURST_WATCHDOG_EN`).

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read`  in  1  line read request; held by the L2 until `pmem_resp`.
- `pmem_write`  in  1  line write request; held by the L2 until `pmem_resp`.
- `pmem_address`  in  32  line address; low `s_offset` bits ignored.
- `pmem_wdata`  in  256  write line.
- `pmem_rdata`  out  256  read line; valid while `pmem_resp` is high.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `burst_read`  out  1  burst read request.
- `burst_write`  out  1  burst write request.
- `burst_address`  out  32  `{addr[31:5], 5'b0}`.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  current read beat.
- `burst_resp`  in  1  beat accepted/valid this cycle.
- `burst_err`  out  1  sticky watchdog error; constant 0 when the watchdog is compiled out.

## Operation

- States: `IDLE`, `READ`, `WRITE`, `DONE`. Moore outputs.
- **IDLE**
  - If `pmem_read`: latch the aligned address, clear the beat counter, go to `READ`.
  - Else if `pmem_write`: latch the address and the full `pmem_wdata`, clear the counter, go to `WRITE`.
  - Read and write together is a protocol violation; read wins.
- **READ**
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1: store `burst_rdata` into line slice `[64*cnt +: 64]` and increment `cnt`.
  - On the 4th beat (`cnt`==3 and `burst_resp`), go to `DONE`.
  - Cycles with `burst_resp`=0 are stalls; beats need not be contiguous.
- **WRITE**
  - `burst_write`=1; `burst_wdata` = latched line slice `[64*cnt +: 64]`.
  - Counter advances on `burst_resp`; go to `DONE` after the 4th beat.
- **DONE**
  - `pmem_resp`=1 for exactly this cycle; `pmem_rdata` = assembled line (read) or undefined-but-stable (write).
  - Always go to `IDLE`.
- The IDLE turnaround cycle guarantees a request still held during the `pmem_resp` cycle is not re-accepted; the L2 drops it by then.
- Beat order: beat 0 = bits 63:0, beat 3 = bits 255:192.
- `burst_address` and `burst_wdata` are stable for the whole burst; the latched copies are immune to `pmem_*` changes mid-burst.
- `burst_resp` in `IDLE` or `DONE` is ignored.

## Timing

- **Reset values:**
  - state `IDLE`, `cnt`=0, `burst_err`=0.
  - All outputs 0, including `pmem_rdata`, `burst_address` and `burst_wdata`.
- **Reset mid-burst:** request lines drop the cycle after `rst` is sampled, and partial data is discarded.
- **Request acceptance:** request sampled in `IDLE` at cycle 0; `burst_read`/`burst_write` high from cycle 1.
- **Latency with contiguous beats at cycles k..k+3:** `pmem_resp` at k+4, and the burst request falls at k+4.
- **Minimum latency (beats starting at cycle 1):** 5 cycles from request to `pmem_resp`.
- **Throughput:** at most one line per 6 cycles (the IDLE cycle is the turnaround).

## Configuration

- Macro: `BURST_WATCHDOG_EN`.
- **Defined:**
  - A counter resets on entry to `READ`/`WRITE` and on every `burst_resp`.
  - Reaching `TIMEOUT` without a beat sets `burst_err`, which stays set until `rst`.
  - The FSM forces `DONE`; on a read, `pmem_rdata` holds whatever beats arrived.
- **Undefined:**
  - No counter logic; `burst_err` is tied 0.
  - The FSM waits indefinitely.

## Structure

- Shared package `cache_types_pkg`:
  - FSM state enum `adaptor_state_t`.
  - `BEATS` = `s_line/s_beat`, beat-counter width `$clog2(BEATS)`.
  - Line and beat typedefs, so the L2 uses the same types.
- Sub-module `burst_watchdog`:
  - Ports: `clk`, `rst`, `start`, `kick`, `expired`.
  - Instantiated only under `BURST_WATCHDOG_EN`.
- The FSM, beat counter and line registers live in `cacheline_adaptor` itself.

## Test plan

- **Read, contiguous beats:**
  - Stimulus: read @0x1234_5678; beats 0x0..0, 0x1..1, 0x2..2, 0x3..3 on cycles 3–6.
  - Response: `burst_address`=0x1234_5660; `pmem_resp` at cycle 7 with `pmem_rdata`={0x3..3, 0x2..2, 0x1..1, 0x0..0}.
- **Write with gaps:**
  - Stimulus: write line 0xAAAA…BBBB; `burst_resp` on cycles 2, 4, 5, 9.
  - Response: `burst_wdata` shows slices 0–3 in order, held stable between beats; `pmem_resp` at cycle 10.
- **Request held through resp:**
  - Stimulus: hold `pmem_read` 1 cycle after `pmem_resp`.
  - Response: no second `burst_read`; a new read presented 2 cycles later starts normally.
- **Simultaneous read+write, address change mid-burst:**
  - Stimulus: assert both requests; change `pmem_address`/`pmem_wdata` during the burst.
  - Response: read burst issued; latched `burst_address` is unchanged.
- **Reset after beat 2 of a read:**
  - Response: next cycle all outputs 0; the following read returns only new data.
- **`BURST_WATCHDOG_EN`, `TIMEOUT`=8:**
  - Stimulus: no `burst_resp`.
  - Response: `burst_err`=1 and `pmem_resp` pulses; `burst_err` stays 1 until `rst`.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the L2 <-> DRAM line path: line/beat widths, beat counter and adaptor FSM states.
package cache_types_pkg;

    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned S_LINE   = 256;
    localparam int unsigned S_BEAT   = 64;
    localparam int unsigned BEATS    = S_LINE / S_BEAT;
    localparam int unsigned CNT_W    = $clog2(BEATS);

    typedef logic [S_LINE-1:0] line_t;
    typedef logic [S_BEAT-1:0] beat_t;
    typedef logic [CNT_W-1:0]  beat_cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } adaptor_state_t;

endpackage

// File: rtl/burst_watchdog.sv
// Stall watchdog for the burst interface: counts cycles since start/kick, asserts expired at TIMEOUT.
module burst_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturates so expired stays asserted until the next start/kick.
    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start || kick) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit pmem line request into a 4-beat 64-bit burst and returns a one-cycle resp.
// Optional stall watchdog enabled with BURST_WATCHDOG_EN.
module cacheline_adaptor
    import cache_types_pkg::*;
#(
    parameter int unsigned s_offset = S_OFFSET,
    parameter int unsigned s_line   = S_LINE,
    parameter int unsigned s_beat   = S_BEAT,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp,
    output logic              burst_err
);

    localparam int unsigned Beats = s_line / s_beat;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    adaptor_state_t              state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [31-s_offset:0]        addr_q, addr_d;
    logic [Beats-1:0][s_beat-1:0] line_q, line_d;
    logic                        last_beat;
    logic                        timeout;

    assign last_beat = (cnt_q == CntW'(Beats - 1));

`ifdef BURST_WATCHDOG_EN
    logic wd_start;
    logic wd_expired;
    logic err_q;

    assign wd_start = (state_q == StIdle) && (pmem_read || pmem_write);

    burst_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_burst_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (wd_start),
        .kick   (burst_resp),
        .expired(wd_expired)
    );

    // A beat arriving on the expiry cycle still counts as progress.
    assign timeout = wd_expired && !burst_resp &&
                     ((state_q == StRead) || (state_q == StWrite));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign burst_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
    assign burst_err      = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[s_offset-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        unique case (state_q)
            StIdle: begin
                // Read wins if both requests are raised together.
                if (pmem_read) begin
                    addr_d  = pmem_address[31:s_offset];
                    cnt_d   = '0;
                    line_d  = '0;
                    state_d = StRead;
                end else if (pmem_write) begin
                    addr_d  = pmem_address[31:s_offset];
                    cnt_d   = '0;
                    line_d  = pmem_wdata;
                    state_d = StWrite;
                end
            end
            StRead: begin
                if (burst_resp) begin
                    line_d[cnt_q] = burst_rdata;
                    cnt_d         = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    assign burst_read    = (state_q == StRead);
    assign burst_write   = (state_q == StWrite);
    assign pmem_resp     = (state_q == StDone);
    assign burst_address = {addr_q, {s_offset{1'b0}}};
    assign burst_wdata   = line_q[cnt_q];
    assign pmem_rdata    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed cases plus randomized line transactions.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;
    logic         burst_err;

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_adaptor #(
        .TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp),
        .burst_err    (burst_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pmem_resp"}, pmem_resp, 0);
        check_eq({tag, "_burst_read"}, burst_read, 0);
        check_eq({tag, "_burst_write"}, burst_write, 0);
        check_eq({tag, "_pmem_rdata"}, pmem_rdata, 0);
        check_eq({tag, "_burst_address"}, burst_address, 0);
        check_eq({tag, "_burst_wdata"}, burst_wdata, 0);
        check_eq({tag, "_burst_err"}, burst_err, 0);
    endtask

    // mode: 0 read, 1 write, 2 read+write together. sched bit c = burst_resp in cycle c
    // (cycle 0 = request cycle); sched == 0 selects random stalls and random data.
    task automatic run_txn(input int mode, input logic [31:0] sched, input logic [31:0] addr,
                           input logic [255:0] wl, output int done_cyc,
                           output logic [255:0] rline);
        logic [63:0]  q[$];
        logic [63:0]  b;
        logic [31:0]  exp_addr;
        logic         eff_rd;
        int           cyc;
        int           k;
        eff_rd       = (mode != 1);
        exp_addr     = addr & 32'hFFFF_FFE0;
        pmem_read    = (mode != 1);
        pmem_write   = (mode != 0);
        pmem_address = addr;
        pmem_wdata   = wl;
        burst_resp   = 1'b0;
        tick();
        cyc = 1;
        while (q.size() < 4 && cyc < 64) begin
            k = q.size();
            check_eq("burst_read", burst_read, eff_rd);
            check_eq("burst_write", burst_write, !eff_rd);
            check_eq("burst_address", burst_address, exp_addr);
            check_eq("pmem_resp_early", pmem_resp, 0);
            if (!eff_rd) begin
                b = 64'(wl >> (64 * k));
                check_eq("burst_wdata", burst_wdata, b);
            end
            // Latched copies must ignore request-side changes mid-burst.
            pmem_address = $urandom();
            pmem_wdata   = {8{$urandom()}};
            if (sched != 0) begin
                burst_resp = (cyc < 32) ? sched[cyc] : 1'b1;
                b          = {16{4'(k)}};
            end else begin
                burst_resp = ($urandom_range(0, 2) != 0);
                b          = {$urandom(), $urandom()};
            end
            burst_rdata = b;
            if (burst_resp) q.push_back(b);
            tick();
            cyc++;
        end
        if (q.size() < 4) check_eq("beat_timeout", 32'(q.size()), 4);
        done_cyc = cyc;
        rline    = pmem_rdata;
        check_eq("pmem_resp", pmem_resp, 1);
        check_eq("burst_read_done", burst_read, 0);
        check_eq("burst_write_done", burst_write, 0);
        if (eff_rd && q.size() == 4) check_eq("pmem_rdata", pmem_rdata, {q[3], q[2], q[1], q[0]});
        // Request was still high during the resp cycle; a stray beat here must be ignored too.
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        burst_resp  = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom(), $urandom()};
        tick();
        check_eq("idle_resp", pmem_resp, 0);
        check_eq("idle_burst_read", burst_read, 0);
        check_eq("idle_burst_write", burst_write, 0);
        check_eq("idle_burst_err", burst_err, 0);
        burst_resp = 1'b0;
    endtask

    int           dc;
    int           cyc;
    int           mode;
    logic [31:0]  sched;
    logic [255:0] rl;
    logic [255:0] wl;

    initial begin
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Read, beats on cycles 3..6, resp at cycle 7.
        run_txn(0, 32'h78, 32'h1234_5678, '0, dc, rl);
        check_eq("rd_done_cycle", 32'(dc), 7);
        check_eq("rd_line", rl, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});

        // Write, beats on cycles 2, 4, 5, 9, resp at cycle 10.
        wl = {64'hAAAA_AAAA_AAAA_AAAA, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hDDDD_DDDD_DDDD_DDDD, 64'hBBBB_BBBB_BBBB_BBBB};
        run_txn(1, 32'h234, 32'h8000_0040, wl, dc, rl);
        check_eq("wr_done_cycle", 32'(dc), 10);

        // Both requests together: read wins.
        run_txn(2, 32'h0, 32'hCAFE_F00D, {8{32'h5A5A_A5A5}}, dc, rl);

        // Reset after the second beat of a read.
        pmem_read    = 1'b1;
        pmem_address = 32'h0BAD_BEEF;
        tick();
        burst_resp  = 1'b1;
        burst_rdata = 64'hDEAD_0000_DEAD_0000;
        tick();
        burst_rdata = 64'hDEAD_1111_DEAD_1111;
        tick();
        rst        = 1'b1;
        pmem_read  = 1'b0;
        burst_resp = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst = 1'b0;
        tick();
        run_txn(0, 32'h0, 32'h0BAD_BEEF, '0, dc, rl);

        // Randomized traffic; contiguous beats from cycle 1 give minimum latency.
        for (int i = 0; i < 40; i++) begin
            mode  = $urandom_range(0, 2);
            sched = ($urandom_range(0, 3) == 0) ? 32'h1E : 32'h0;
            wl    = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            run_txn(mode, sched, $urandom(), wl, dc, rl);
            if (sched != 0) check_eq("min_latency", 32'(dc), 5);
        end

`ifdef BURST_WATCHDOG_EN
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1000;
        burst_resp   = 1'b0;
        tick();
        cyc = 1;
        while (!pmem_resp && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq("wd_resp", pmem_resp, 1);
        check_eq("wd_err", burst_err, 1);
        pmem_read = 1'b0;
        tick();
        tick();
        check_eq("wd_err_sticky", burst_err, 1);
        check_eq("wd_idle_read", burst_read, 0);
        rst = 1'b1;
        tick();
        check_eq("wd_err_reset", burst_err, 0);
        rst = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
